// File: rtl/pi1_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pi1_arbiter
// Description : Two-master to one-slave arbiter for a PI1-style bus. A grant is
//               issued combinationally from IDLE, held until the slave accepts,
//               and read data is routed back to the owning master one cycle
//               after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module pi1_arbiter #(
    parameter int ARCHBITSZ = 32,
    parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic [1:0]             m0_op_i,
    input  logic [ADDRBITSZ-1:0]   m0_addr_i,
    input  logic [ARCHBITSZ-1:0]   m0_data_i,
    output logic [ARCHBITSZ-1:0]   m0_data_o,
    input  logic [ARCHBITSZ/8-1:0] m0_sel_i,
    output logic                   m0_rdy_o,
    output logic [ADDRBITSZ-1:0]   m0_mapsz_o,

    input  logic [1:0]             m1_op_i,
    input  logic [ADDRBITSZ-1:0]   m1_addr_i,
    input  logic [ARCHBITSZ-1:0]   m1_data_i,
    output logic [ARCHBITSZ-1:0]   m1_data_o,
    input  logic [ARCHBITSZ/8-1:0] m1_sel_i,
    output logic                   m1_rdy_o,
    output logic [ADDRBITSZ-1:0]   m1_mapsz_o,

    output logic [1:0]             s_op_o,
    output logic [ADDRBITSZ-1:0]   s_addr_o,
    output logic [ARCHBITSZ-1:0]   s_data_o,
    input  logic [ARCHBITSZ-1:0]   s_data_i,
    output logic [ARCHBITSZ/8-1:0] s_sel_o,
    input  logic                   s_rdy_i,
    input  logic [ADDRBITSZ-1:0]   s_mapsz_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt;
    logic   last_r;        // master granted by the most recent accept
    logic   rsp_valid_r;   // read response expected on s_data_i this cycle
    logic   rsp_owner_r;   // master that owns that response

    logic   req0;
    logic   req1;
    logic   gnt_valid;
    logic   gnt_sel;
    logic   accept;

    assign req0 = (m0_op_i != 2'b00);
    assign req1 = (m1_op_i != 2'b00);

    // Next-state and grant selection; a held grant is released when its
    // master withdraws, and reset suppresses any grant immediately.
    always_comb begin
        state_nxt = state_r;
        gnt_valid = 1'b0;
        gnt_sel   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0 && req1) begin
                    gnt_valid = 1'b1;
                    gnt_sel   = ~last_r;
                end else if (req0) begin
                    gnt_valid = 1'b1;
                    gnt_sel   = 1'b0;
                end else if (req1) begin
                    gnt_valid = 1'b1;
                    gnt_sel   = 1'b1;
                end
            end
            OWN0: begin
                gnt_valid = req0;
                gnt_sel   = 1'b0;
            end
            OWN1: begin
                gnt_valid = req1;
                gnt_sel   = 1'b1;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_sel   = 1'b0;
            end
        endcase

        if (rst_i) begin
            gnt_valid = 1'b0;
        end

        accept = gnt_valid && s_rdy_i;

        if (!gnt_valid || accept) begin
            state_nxt = IDLE;
        end else begin
            state_nxt = gnt_sel ? OWN1 : OWN0;
        end
    end

    // Route the granted master's request to the slave; zero when idle.
    always_comb begin
        s_op_o   = '0;
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        if (gnt_valid) begin
            if (gnt_sel) begin
                s_op_o   = m1_op_i;
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
                s_sel_o  = m1_sel_i;
            end else begin
                s_op_o   = m0_op_i;
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
                s_sel_o  = m0_sel_i;
            end
        end
    end

    assign m0_rdy_o   = accept && !gnt_sel;
    assign m1_rdy_o   = accept &&  gnt_sel;

    assign m0_data_o  = (rsp_valid_r && !rsp_owner_r) ? s_data_i : '0;
    assign m1_data_o  = (rsp_valid_r &&  rsp_owner_r) ? s_data_i : '0;

    assign m0_mapsz_o = s_mapsz_i;
    assign m1_mapsz_o = s_mapsz_i;

    // State, fairness and response tracking; reset forces master 0 to win
    // the first contention and discards any pending response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            last_r      <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_owner_r <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            rsp_valid_r <= accept && s_op_o[1];
            if (accept) begin
                last_r      <= gnt_sel;
                rsp_owner_r <= gnt_sel;
            end
        end
    end

endmodule
`default_nettype wire
